// File: rtl/packet_tagger.sv
// Ingress tagger: stamps each packet with a wrapping reorder tag and throttles the source when all buffer slots are held.
// Optional build macro PACKET_TAGGER_RELEASE_CHECK_EN enables checking of released tags against the oldest outstanding tag.
module packet_tagger #(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50,
  parameter int DATA_WIDTH           = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_TDATA,
  input  logic                  s_TLAST,
  input  logic                  s_TVALID,
  output logic                  s_TREADY,
  output logic [DATA_WIDTH-1:0] buffer_TDATA,
  output logic                  buffer_TLAST,
  output logic                  buffer_TVALID,
  input  logic                  buffer_TREADY,
  output logic [TAG_WIDTH-1:0]  reorder_tag_in,
  input  logic                  tag_release_valid,
  input  logic [TAG_WIDTH-1:0]  tag_release,
  output logic [TAG_WIDTH:0]    tags_outstanding,
  output logic                  release_error
);

  typedef enum logic {
    IDLE,
    IN_PKT
  } pkt_state_t;

  localparam logic [TAG_WIDTH:0]   SLOTS    = (TAG_WIDTH+1)'(CIRCULAR_BUFFER_SIZE);
  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);

  pkt_state_t           state, state_next;
  logic [TAG_WIDTH-1:0] next_tag;
  logic [TAG_WIDTH-1:0] oldest_tag;
  logic                 stall;
  logic                 accept;
  logic                 pkt_start;
  logic                 rel_underflow;
  logic                 rel_ok;
  logic                 rel_mismatch;

  function automatic logic [TAG_WIDTH-1:0] wrap_inc(input logic [TAG_WIDTH-1:0] t);
    return (t == LAST_TAG) ? '0 : t + 1'b1;
  endfunction

  // Stall only between packets so an admitted packet always completes.
  assign stall     = (state == IDLE) && (tags_outstanding == SLOTS);
  assign s_TREADY  = ~rst & (~buffer_TVALID | buffer_TREADY) & ~stall;
  assign accept    = s_TVALID & s_TREADY;
  assign pkt_start = accept & (state == IDLE);

  assign rel_underflow = tag_release_valid & (tags_outstanding == '0);
  assign rel_ok        = tag_release_valid & ~rel_underflow;

`ifdef PACKET_TAGGER_RELEASE_CHECK_EN
  assign rel_mismatch = rel_ok & (tag_release != oldest_tag);
`else
  logic unused_release;
  assign unused_release = ^tag_release;
  assign rel_mismatch   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) state_next = s_TLAST ? IDLE : IN_PKT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer_TDATA   <= '0;
      buffer_TLAST   <= 1'b0;
      buffer_TVALID  <= 1'b0;
      reorder_tag_in <= '0;
    end else if (accept) begin
      buffer_TDATA   <= s_TDATA;
      buffer_TLAST   <= s_TLAST;
      buffer_TVALID  <= 1'b1;
      reorder_tag_in <= next_tag;
    end else if (buffer_TREADY) begin
      buffer_TVALID  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_tag         <= '0;
      oldest_tag       <= '0;
      tags_outstanding <= '0;
      release_error    <= 1'b0;
    end else begin
      if (accept && s_TLAST) next_tag <= wrap_inc(next_tag);
      if (rel_ok) oldest_tag <= wrap_inc(oldest_tag);
      case ({pkt_start, rel_ok})
        2'b10:   tags_outstanding <= tags_outstanding + 1'b1;
        2'b01:   tags_outstanding <= tags_outstanding - 1'b1;
        default: tags_outstanding <= tags_outstanding;
      endcase
      if (rel_underflow || rel_mismatch) release_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_tagger.sv
// Scoreboard bench for packet_tagger: directed tag/stall/release/reset scenarios plus randomized back-pressure traffic.
module tb_packet_tagger;

  localparam int TW   = 2;
  localparam int SIZE = 3;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_TDATA = '0;
  logic          s_TLAST = 1'b0;
  logic          s_TVALID = 1'b0;
  logic          s_TREADY;
  logic [DW-1:0] buffer_TDATA;
  logic          buffer_TLAST;
  logic          buffer_TVALID;
  logic          buffer_TREADY = 1'b1;
  logic [TW-1:0] reorder_tag_in;
  logic          tag_release_valid = 1'b0;
  logic [TW-1:0] tag_release = '0;
  logic [TW:0]   tags_outstanding;
  logic          release_error;

  packet_tagger #(
    .TAG_WIDTH(TW),
    .CIRCULAR_BUFFER_SIZE(SIZE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_TDATA(s_TDATA),
    .s_TLAST(s_TLAST),
    .s_TVALID(s_TVALID),
    .s_TREADY(s_TREADY),
    .buffer_TDATA(buffer_TDATA),
    .buffer_TLAST(buffer_TLAST),
    .buffer_TVALID(buffer_TVALID),
    .buffer_TREADY(buffer_TREADY),
    .reorder_tag_in(reorder_tag_in),
    .tag_release_valid(tag_release_valid),
    .tag_release(tag_release),
    .tags_outstanding(tags_outstanding),
    .release_error(release_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [TW-1:0] tag;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Reference model: counts of packets started, completed and released since reset.
  int    m_started, m_done, m_rel;
  bit    m_inpkt, m_err;
  bit    acc, pend, rand_rdy, auto_rel;
  beat_t pend_beat;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int model_cnt();
    return m_started - m_rel;
  endfunction

  task automatic step();
    bit    start;
    bit    exp_rdy;
    beat_t b;
    if (rand_rdy) buffer_TREADY = ($urandom_range(99) < 60);
    if (auto_rel && !tag_release_valid && model_cnt() > 0 && $urandom_range(3) == 0) begin
      tag_release_valid = 1'b1;
      tag_release       = TW'(m_rel % SIZE);
    end
    @(negedge clk);
    if (pend) begin
      check("latency_valid", 64'(buffer_TVALID), 64'd1);
      check("latency_data", 64'(buffer_TDATA), 64'(pend_beat.data));
      check("latency_tag", 64'(reorder_tag_in), 64'(pend_beat.tag));
      pend = 1'b0;
    end
    check("tags_outstanding", 64'(tags_outstanding), 64'(model_cnt()));
    check("release_error", 64'(release_error), 64'(m_err));
    exp_rdy = !(!m_inpkt && model_cnt() == SIZE) && (!buffer_TVALID || buffer_TREADY);
    check("s_TREADY", 64'(s_TREADY), 64'(exp_rdy));
    acc   = s_TVALID && s_TREADY;
    start = 1'b0;
    if (acc) begin
      start  = !m_inpkt;
      b.data = s_TDATA;
      b.last = s_TLAST;
      b.tag  = TW'(m_done % SIZE);
      exp_q.push_back(b);
      pend_beat = b;
      pend      = 1'b1;
      m_inpkt   = !s_TLAST;
      if (s_TLAST) m_done++;
    end
    if (tag_release_valid) begin
      if (model_cnt() == 0) m_err = 1'b1;
      else begin
`ifdef PACKET_TAGGER_RELEASE_CHECK_EN
        if (int'(tag_release) != m_rel % SIZE) m_err = 1'b1;
`endif
        m_rel++;
      end
    end
    if (start) m_started++;
    @(posedge clk);
    #1;
    tag_release_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int rel_at);
    int waits;
    for (int i = 0; i < len; i++) begin
      s_TVALID = 1'b1;
      s_TDATA  = DW'($urandom);
      s_TLAST  = (i == len - 1);
      acc      = 1'b0;
      waits    = 0;
      while (!acc && waits < 200) begin
        if (i == 0 && waits == rel_at) begin
          tag_release_valid = 1'b1;
          tag_release       = TW'(m_rel % SIZE);
        end
        step();
        waits++;
      end
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic idle(input int n);
    s_TVALID = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rel_idle(input int n, input int tag_off);
    s_TVALID = 1'b0;
    for (int i = 0; i < n; i++) begin
      tag_release_valid = 1'b1;
      tag_release       = TW'((m_rel + tag_off) % SIZE);
      step();
    end
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    s_TVALID          = 1'b0;
    tag_release_valid = 1'b0;
    #1;
    check("rst_TVALID", 64'(buffer_TVALID), 64'd0);
    check("rst_TDATA", 64'(buffer_TDATA), 64'd0);
    check("rst_TLAST", 64'(buffer_TLAST), 64'd0);
    check("rst_tag", 64'(reorder_tag_in), 64'd0);
    check("rst_count", 64'(tags_outstanding), 64'd0);
    check("rst_error", 64'(release_error), 64'd0);
    check("rst_s_TREADY", 64'(s_TREADY), 64'd0);
    m_started = 0;
    m_done    = 0;
    m_rel     = 0;
    m_inpkt   = 1'b0;
    m_err     = 1'b0;
    pend      = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks hold stability under back-pressure.
  bit    hold = 1'b0;
  beat_t held, got;
  always @(negedge clk) begin
    if (rst) hold = 1'b0;
    else begin
      if (hold) begin
        check("hold_valid", 64'(buffer_TVALID), 64'd1);
        check("hold_data", 64'(buffer_TDATA), 64'(held.data));
        check("hold_last", 64'(buffer_TLAST), 64'(held.last));
        check("hold_tag", 64'(reorder_tag_in), 64'(held.tag));
      end
      if (buffer_TVALID && buffer_TREADY) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else begin
          got = exp_q.pop_front();
          check("out_data", 64'(buffer_TDATA), 64'(got.data));
          check("out_last", 64'(buffer_TLAST), 64'(got.last));
          check("out_tag", 64'(reorder_tag_in), 64'(got.tag));
        end
      end
      hold      = buffer_TVALID && !buffer_TREADY;
      held.data = buffer_TDATA;
      held.last = buffer_TLAST;
      held.tag  = reorder_tag_in;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_rdy = 1'b0;
    auto_rel = 1'b0;
    pend     = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Three back-to-back 2-beat packets fill all slots; the fourth stalls until a release.
    for (int p = 0; p < 3; p++) send_pkt(2, -1);
    send_pkt(2, 3);
    idle(1);

    // Drain to one outstanding, then a single-beat start coincident with a release.
    rel_idle(2, 0);
    send_pkt(1, 0);
    idle(2);

    // Reset in the middle of a 3-beat packet; the resent packet restarts at tag 0.
    s_TVALID = 1'b1;
    s_TDATA  = DW'($urandom);
    s_TLAST  = 1'b0;
    step();
    do_reset();
    send_pkt(1, -1);
    idle(2);

    // Out-of-order release (oldest is 0, release 2), then underflow after reset.
    rel_idle(1, 2);
    idle(2);
    do_reset();
    rel_idle(1, 0);
    idle(2);

    // Randomized traffic with 60% sink readiness and random in-order releases.
    do_reset();
    rand_rdy = 1'b1;
    auto_rel = 1'b1;
    for (int p = 0; p < 10; p++) send_pkt(int'($urandom_range(4, 1)), -1);
    s_TVALID      = 1'b0;
    rand_rdy      = 1'b0;
    auto_rel      = 1'b0;
    buffer_TREADY = 1'b1;
    idle(6);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_tagger.md
# packet_tagger

Ingress stage placed directly upstream of `circular_buffer`. It accepts AXI-Stream packets from the network side, stamps every beat of each packet with a sequential reorder tag (0 … CIRCULAR_BUFFER_SIZE-1, wrapping), and forwards them on the `buffer_*` interface with `reorder_tag_in`. It tracks how many tags are outstanding and back-pressures the source when every buffer slot is in use. Slots are returned in order by the circular buffer's tag-release pulse.

## Interface
- `TAG_WIDTH`, 6, width of reorder tag; CIRCULAR_BUFFER_SIZE ≤ 2^TAG_WIDTH required
- `CIRCULAR_BUFFER_SIZE`, 50, number of tags/slots in rotation
- `DATA_WIDTH`, 64, TDATA width

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_TDATA`  in  DATA_WIDTH  source data
- `s_TLAST`  in  1  last beat of packet
- `s_TVALID`  in  1  source valid
- `s_TREADY`  out  1  ready to source
- `buffer_TDATA`  out  DATA_WIDTH  data to circular buffer (registered)
- `buffer_TLAST`  out  1  last beat (registered)
- `buffer_TVALID`  out  1  valid (registered)
- `buffer_TREADY`  in  1  circular buffer ready
- `reorder_tag_in`  out  TAG_WIDTH  tag of current output beat (registered)
- `tag_release_valid`  in  1  one-cycle pulse: circular buffer has retired a tag
- `tag_release`  in  TAG_WIDTH  tag being retired
- `tags_outstanding`  out  TAG_WIDTH+1  count of tags currently allocated
- `release_error`  out  1  sticky release-protocol error

## Operation
- One-entry output register. Source beat accepted when `s_TVALID & s_TREADY`; it is loaded into the output register with the current tag.
- `s_TREADY = ~rst & (~buffer_TVALID | buffer_TREADY) & ~stall`. Combinational path from `buffer_TREADY` to `s_TREADY` is permitted; throughput one beat/cycle.
- `in_pkt` flag: set on an accepted non-last beat, cleared on an accepted TLAST beat. The beat accepted with `in_pkt=0` is a packet start.
- `stall = ~in_pkt & (tags_outstanding == CIRCULAR_BUFFER_SIZE)`. Stalling occurs only between packets and never mid-packet.
- On packet start: `tags_outstanding` +1. The current tag is held for all beats of the packet.
- On accepted TLAST: `next_tag` advances; CIRCULAR_BUFFER_SIZE-1 wraps to 0.
- On `tag_release_valid`: `tags_outstanding` -1 and `oldest_tag` advances with the same wrap rule.
- Packet start and release in the same cycle: net change 0.
- Release with `tags_outstanding == 0`: ignored (count stays 0) and `release_error` is set.
- Single-beat packet (TLAST on the start beat): both increment and tag advance apply in the same cycle.
- `rst` mid-packet: all state is cleared, the partial packet is discarded, and the source must resend it.

## Timing
- Reset values: `buffer_TDATA`=0, `buffer_TLAST`=0, `buffer_TVALID`=0, `reorder_tag_in`=0, `tags_outstanding`=0, `release_error`=0. `s_TREADY`=0 while `rst` is high. Internal `next_tag`=0, `oldest_tag`=0, `in_pkt`=0.
- Latency: an accepted beat appears on `buffer_*` the next cycle.
- `buffer_TVALID` remains high with stable data and tag until `buffer_TREADY` is sampled high.
- `stall` uses the registered `tags_outstanding`. A release in cycle N unblocks a start no earlier than cycle N+1.

## Configuration
- `PACKET_TAGGER_RELEASE_CHECK_EN`
  - Defined: `tag_release` is compared against `oldest_tag`. A mismatch sets `release_error`, and the count and `oldest_tag` still update.
  - Not defined: `tag_release` is ignored, only `tag_release_valid` is counted, and the underflow case alone sets `release_error`.

## Test plan
- SIZE=3, `buffer_TREADY`=1, send three 2-beat packets back-to-back -> tags 0,0,1,1,2,2 on `reorder_tag_in`, each one cycle after acceptance. `tags_outstanding` reaches 3, then `s_TREADY`=0 at the fourth packet start.
- With the stalled fourth packet pending, pulse `tag_release_valid` with `tag_release`=0 -> `s_TREADY` rises the next cycle and the fourth packet gets tag 0 (wrap).
- Toggle `buffer_TREADY` pseudo-randomly at 60% across ten packets -> no beat lost or duplicated, data/tag stable while stalled, tag sequence 0,1,2,0,1,… matches the reference model.
- Single-beat packet start coincident with a release -> `tags_outstanding` unchanged and `next_tag` +1.
- Release tag 2 while `oldest_tag`=0 -> `release_error`=1 when the macro is defined, 0 when it is not. Release at count 0 -> `release_error`=1 in both builds.
- Assert `rst` after beat 1 of a 3-beat packet -> all outputs at reset values within the same cycle. The next packet starts with tag 0 and count 1.
